// File: rtl/pg_pkg.sv
// Shared power-gating definitions: state encoding used by the sequencer,
// the power-management status registers and the debug bus.
package pg_pkg;

  localparam int PG_STATE_W = 3;

  typedef enum logic [PG_STATE_W-1:0] {
    PG_ON      = 3'd0,
    PG_SAVE    = 3'd1,
    PG_ISO     = 3'd2,
    PG_PDN     = 3'd3,
    PG_OFF     = 3'd4,
    PG_PUP     = 3'd5,
    PG_DEISO   = 3'd6,
    PG_RESTORE = 3'd7
  } pg_state_e;

  function automatic int pg_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b; else m = m;
    if (c > m) m = c; else m = m;
    if (d > m) m = d; else m = m;
    return m;
  endfunction

endpackage

// File: rtl/pg_delay_counter.sv
// Loadable saturating down-counter; expired is high while the count is zero.
// Shared by every timed state of the power-gating sequencer.
module pg_delay_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload on strobe, otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= {W{1'b0}};
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/pg_sequencer.sv
// Power-gating sequencer: save, isolate, switch off; then switch on, settle,
// de-isolate, restore. Macro PG_ACK_TIMEOUT_EN enables the save-ack timeout/abort.
module pg_sequencer
  import pg_pkg::*;
#(
  parameter int ACK_TIMEOUT    = 16,
  parameter int ISO_SETUP      = 2,
  parameter int PWR_SETTLE     = 8,
  parameter int RESTORE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sleep_req,
  input  logic       wake_req,
  input  logic       ack_from_block,
  output logic       save_state,
  output logic       iso_en,
  output logic       pwr_en,
  output logic       restore_state,
  output logic       domain_on,
  output logic       abort_pulse,
  output logic [2:0] pg_state
);

  localparam int CNT_W = $clog2(pg_max4(ACK_TIMEOUT, ISO_SETUP, PWR_SETTLE, RESTORE_CYCLES)) + 1;

  pg_state_e  state_q, state_d;
  logic       save_q, save_d, iso_q, iso_d, pwr_q, pwr_d;
  logic       restore_q, restore_d, dom_q, dom_d, abort_q, abort_d;
  logic       cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic       cnt_expired;

  pg_delay_counter #(.W(CNT_W)) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .expired  (cnt_expired)
  );

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    abort_d = 1'b0;
    case (state_q)
      PG_ON:      if (sleep_req) state_d = PG_SAVE; else state_d = PG_ON;
      PG_SAVE: begin
        if (ack_from_block) begin
          state_d = PG_ISO;
        end else begin
`ifdef PG_ACK_TIMEOUT_EN
          if (cnt_expired) begin
            state_d = PG_ON;
            abort_d = 1'b1;
          end else begin
            state_d = PG_SAVE;
          end
`else
          state_d = PG_SAVE;
`endif
        end
      end
      PG_ISO:     if (cnt_expired) state_d = PG_PDN;     else state_d = PG_ISO;
      PG_PDN:     if (cnt_expired) state_d = PG_OFF;     else state_d = PG_PDN;
      PG_OFF:     if (wake_req)    state_d = PG_PUP;     else state_d = PG_OFF;
      PG_PUP:     if (cnt_expired) state_d = PG_DEISO;   else state_d = PG_PUP;
      PG_DEISO:   if (cnt_expired) state_d = PG_RESTORE; else state_d = PG_DEISO;
      PG_RESTORE: if (cnt_expired) state_d = PG_ON;      else state_d = PG_RESTORE;
      default:    state_d = PG_ON;
    endcase
  end

  // Counter reload and Moore outputs, all keyed on the state being entered
  // so the output flops line up with the state register.
  always_comb begin
    cnt_load  = (state_d != state_q);
    cnt_val   = {CNT_W{1'b0}};
    save_d    = 1'b0;
    iso_d     = 1'b0;
    pwr_d     = 1'b1;
    restore_d = 1'b0;
    dom_d     = 1'b0;
    case (state_d)
      PG_ON:      dom_d = 1'b1;
      PG_SAVE: begin
        save_d  = 1'b1;
        cnt_val = CNT_W'(ACK_TIMEOUT - 1);
      end
      PG_ISO: begin
        iso_d   = 1'b1;
        cnt_val = CNT_W'(ISO_SETUP - 1);
      end
      PG_PDN: begin
        iso_d = 1'b1;
        pwr_d = 1'b0;
      end
      PG_OFF: begin
        iso_d = 1'b1;
        pwr_d = 1'b0;
      end
      PG_PUP: begin
        iso_d   = 1'b1;
        cnt_val = CNT_W'(PWR_SETTLE - 1);
      end
      PG_DEISO: begin
        iso_d   = 1'b1;
        cnt_val = CNT_W'(ISO_SETUP - 1);
      end
      PG_RESTORE: begin
        restore_d = 1'b1;
        cnt_val   = CNT_W'(RESTORE_CYCLES - 1);
      end
      default: begin
        iso_d = 1'b0;
        pwr_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset lands in ON with power up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PG_ON;
      save_q    <= 1'b0;
      iso_q     <= 1'b0;
      pwr_q     <= 1'b1;
      restore_q <= 1'b0;
      dom_q     <= 1'b1;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      save_q    <= save_d;
      iso_q     <= iso_d;
      pwr_q     <= pwr_d;
      restore_q <= restore_d;
      dom_q     <= dom_d;
      abort_q   <= abort_d;
    end
  end

  assign save_state    = save_q;
  assign iso_en        = iso_q;
  assign pwr_en        = pwr_q;
  assign restore_state = restore_q;
  assign domain_on     = dom_q;
  assign abort_pulse   = abort_q;
  assign pg_state      = state_q;

endmodule

// File: tb/tb_pg_sequencer.sv
// Self-checking bench for pg_sequencer: per-cycle expected output vectors are
// queued when stimulus is applied and popped against the DUT each cycle.
module tb_pg_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sleep_req = 1'b0;
  logic       wake_req = 1'b0;
  logic       ack_from_block = 1'b0;
  logic       save_state, iso_en, pwr_en, restore_state, domain_on, abort_pulse;
  logic [2:0] pg_state;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];
  logic blk_en = 1'b1;
  int   save_cycles = 0;

  pg_sequencer dut (
    .clk(clk), .rst_n(rst_n), .sleep_req(sleep_req), .wake_req(wake_req),
    .ack_from_block(ack_from_block), .save_state(save_state), .iso_en(iso_en),
    .pwr_en(pwr_en), .restore_state(restore_state), .domain_on(domain_on),
    .abort_pulse(abort_pulse), .pg_state(pg_state)
  );

  always #5 clk = ~clk;

  // Gated-block model: ack is raised in the third cycle save_state is high.
  always @(negedge clk) begin
    if (save_state) save_cycles = save_cycles + 1;
    else            save_cycles = 0;
    ack_from_block = blk_en && save_state && (save_cycles >= 3);
  end

  // Expected {save, iso, pwr, restore, domain_on, abort, state} from the state table.
  function automatic logic [8:0] exp_vec(input logic [2:0] st, input logic ab);
    logic [5:0] o;
    case (st)
      3'd0:    o = 6'b001010;
      3'd1:    o = 6'b101000;
      3'd2:    o = 6'b011000;
      3'd3:    o = 6'b010000;
      3'd4:    o = 6'b010000;
      3'd5:    o = 6'b011000;
      3'd6:    o = 6'b011000;
      default: o = 6'b001100;
    endcase
    o[0] = ab;
    return {o, st};
  endfunction

  function automatic logic [8:0] obs_vec();
    return {save_state, iso_en, pwr_en, restore_state, domain_on, abort_pulse, pg_state};
  endfunction

  task automatic push_n(input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_vec(st, 1'b0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] e;
    #2 rst_n = 1'b0;
    #1;
    e = exp_vec(3'd0, 1'b0);
    checks++;
    if (obs_vec() !== e) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", obs_vec(), e);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sleep();
    logic [8:0] e;
    int save_hi = 0;
    @(negedge clk);
    sleep_req = 1'b1;
    push_n(3'd1, 3); push_n(3'd2, 2); push_n(3'd3, 1); push_n(3'd4, 1);
    while (exp_q.size() > 0) begin
      tick();
      sleep_req = 1'b0;
      e = exp_q.pop_front();
      if (save_state) save_hi++;
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL sleep_seq: got %b expected %b", obs_vec(), e);
      end
    end
    checks++;
    if (save_hi !== 3) begin
      errors++;
      $display("FAIL sleep_save_width: got %0d expected 3", save_hi);
    end
  endtask

  task automatic test_wake();
    logic [8:0] e;
    int iso_hi = 0;
    @(negedge clk);
    wake_req = 1'b1;
    push_n(3'd5, 8); push_n(3'd6, 2); push_n(3'd7, 2); push_n(3'd0, 2);
    while (exp_q.size() > 0) begin
      tick();
      wake_req = 1'b0;
      e = exp_q.pop_front();
      if (iso_en) iso_hi++;
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL wake_seq: got %b expected %b", obs_vec(), e);
      end
    end
    checks++;
    if (iso_hi !== 10) begin
      errors++;
      $display("FAIL wake_iso_width: got %0d expected 10", iso_hi);
    end
  endtask

  task automatic test_timeout();
    logic [8:0] e;
    int pwr_drop = 0;
    blk_en = 1'b0;
    @(negedge clk);
    sleep_req = 1'b1;
`ifdef PG_ACK_TIMEOUT_EN
    push_n(3'd1, 16);
    exp_q.push_back(exp_vec(3'd0, 1'b1));
    push_n(3'd0, 2);
`else
    push_n(3'd1, 100);
`endif
    while (exp_q.size() > 0) begin
      tick();
      sleep_req = 1'b0;
      e = exp_q.pop_front();
      if (!pwr_en) pwr_drop++;
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL timeout_seq: got %b expected %b", obs_vec(), e);
      end
    end
    checks++;
    if (pwr_drop !== 0) begin
      errors++;
      $display("FAIL timeout_pwr_kept: got %0d low cycles expected 0", pwr_drop);
    end
    blk_en = 1'b1;
`ifndef PG_ACK_TIMEOUT_EN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
  endtask

  task automatic test_reset_in_off();
    logic [8:0] e;
    @(negedge clk);
    sleep_req = 1'b1;
    tick();
    sleep_req = 1'b0;
    repeat (6) tick();
    checks++;
    if (pg_state !== 3'd4) begin
      errors++;
      $display("FAIL reach_off: got %0d expected 4", pg_state);
    end
    #2 rst_n = 1'b0;
    #1;
    e = exp_vec(3'd0, 1'b0);
    checks++;
    if (obs_vec() !== e) begin
      errors++;
      $display("FAIL reset_in_off: got %b expected %b", obs_vec(), e);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_both_high();
    logic [8:0] e;
    int off_cnt = 0;
    sleep_req = 1'b1;
    wake_req  = 1'b1;
    for (int l = 0; l < 3; l++) begin
      push_n(3'd1, 3); push_n(3'd2, 2); push_n(3'd3, 1); push_n(3'd4, 1);
      push_n(3'd5, 8); push_n(3'd6, 2); push_n(3'd7, 2); push_n(3'd0, 1);
    end
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      if (pg_state === 3'd4) off_cnt++;
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL both_high_seq: got %b expected %b", obs_vec(), e);
      end
      checks++;
      if (!pwr_en && !iso_en) begin
        errors++;
        $display("FAIL iso_invariant: pwr_en=%b iso_en=%b expected iso_en=1", pwr_en, iso_en);
      end
    end
    checks++;
    if (off_cnt !== 3) begin
      errors++;
      $display("FAIL both_high_loops: got %0d expected 3", off_cnt);
    end
    sleep_req = 1'b0;
    wake_req  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sleep();
    test_wake();
    test_timeout();
    test_reset_in_off();
    test_both_high();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pg_sequencer.md
Name: pg_sequencer

Overview:
- Power-gating sequencer that sits directly upstream of a gated block and drives its `save_state` input.
- Consumes the block's `ack_from_block` return signal.
- Runs the full sleep sequence: state save, isolation, power-switch off. Then runs the reverse wake sequence: power-switch on, settle, isolation release, state restore.
- Instantiated once per power domain.

Parameters:
- ACK_TIMEOUT, 16, max cycles in SAVE waiting for `ack_from_block` before abort (must be ≥4).
- ISO_SETUP, 2, cycles between isolation assert and power-switch off; also cycles between power stable and isolation release.
- PWR_SETTLE, 8, cycles after `pwr_en` rises before the domain is considered stable.
- RESTORE_CYCLES, 2, width of the `restore_state` pulse, in cycles.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- sleep_req  input  1  level request to power the domain down; sampled in ON only
- wake_req  input  1  level request to power the domain up; sampled in OFF only
- ack_from_block  input  1  save-complete acknowledge from the gated block
- save_state  output  1  save command to the gated block
- iso_en  output  1  isolation clamp enable, high = outputs clamped
- pwr_en  output  1  power-switch enable, high = domain powered
- restore_state  output  1  restore command to the gated block
- domain_on  output  1  high only in state ON
- abort_pulse  output  1  1-cycle pulse on save-ack timeout
- pg_state  output  3  current state encoding, for debug

Behaviour:
- Reset: state = ON.
  - `pwr_en` = 1; `domain_on` = 1.
  - All other outputs = 0; counter = 0.
  - Reset is asynchronous and legal in any state. It forces ON immediately, including mid-sequence with power off.
- All outputs are registered and are pure functions of the state register (Moore). No combinational path from any input to any output.
- Single down-counter, width `$clog2` of the largest parameter + 1. Loaded on every state entry; it never wraps.
- State encoding: ON=0, SAVE=1, ISO=2, PDN=3, OFF=4, PUP=5, DEISO=6, RESTORE=7.
- ON: `pwr_en` = 1, `domain_on` = 1. If `sleep_req` = 1, go to SAVE. `wake_req` is ignored.
- SAVE: `save_state` = 1.
  - `ack_from_block` = 1: go to ISO.
  - Otherwise, when the counter (loaded ACK_TIMEOUT) expires: go to ON and pulse `abort_pulse` for 1 cycle.
  - Ack wins if ack and timeout occur in the same cycle.
- ISO: `save_state` = 0, `iso_en` = 1. Stay ISO_SETUP cycles, then go to PDN.
- PDN: `iso_en` = 1, `pwr_en` = 0. Stay 1 cycle, then go to OFF.
- OFF: `iso_en` = 1, `pwr_en` = 0.
  - `ack_from_block` is ignored; it may still be falling.
  - If `wake_req` = 1, go to PUP. `sleep_req` is ignored.
- PUP: `pwr_en` = 1, `iso_en` = 1. Stay PWR_SETTLE cycles, then go to DEISO.
- DEISO: `pwr_en` = 1, `iso_en` = 1. Stay ISO_SETUP cycles, then go to RESTORE.
- RESTORE: `iso_en` = 0, `restore_state` = 1. Stay RESTORE_CYCLES cycles, then go to ON.
- Invariant: `iso_en` = 1 in every cycle where `pwr_en` = 0. `iso_en` rises at least ISO_SETUP cycles before `pwr_en` falls.
- `sleep_req` and `wake_req` both high: only the request valid in the current state acts.
- Minimum sleep-to-ON round trip is 1 + ack latency + ISO_SETUP + 1 + 1 + PWR_SETTLE + ISO_SETUP + RESTORE_CYCLES cycles.

Optional Feature:
- Macro: PG_ACK_TIMEOUT_EN.
- Defined: the SAVE timeout and abort path are active as described above.
- Undefined:
  - SAVE waits indefinitely for `ack_from_block`.
  - `abort_pulse` is tied 0.
  - The timeout compare logic is removed; ACK_TIMEOUT is unused.

Decomposition:
- Shared package pg_pkg holds:
  - the state typedef/localparams (ON..RESTORE, 3 bits);
  - PG_STATE_W = 3.
- The package is reused by the power-management status registers and the debug bus.
- One natural sub-module: pg_delay_counter. It provides a loadable down-counter with load value, load strobe and an expire flag, and is reused for all timed states.
- The FSM stays in pg_sequencer.

Test Plan:
- Nominal sleep against a gated block model that returns ack 3 cycles after `save_state` rises (defaults):
  - `save_state` is high 3 cycles;
  - `iso_en` rises the cycle after ack;
  - `pwr_en` falls 2 cycles later;
  - `pg_state` = 4.
- Wake from OFF with `wake_req` = 1:
  - `pwr_en` rises next cycle;
  - `iso_en` stays high for 8 + 2 cycles;
  - `restore_state` is high 2 cycles;
  - then `domain_on` = 1, `pg_state` = 0.
- No ack, PG_ACK_TIMEOUT_EN defined:
  - after 16 SAVE cycles, `abort_pulse` = 1 for exactly 1 cycle;
  - state returns to ON;
  - `pwr_en` never drops.
- Same stimulus with the macro undefined: still in SAVE after 100 cycles, `abort_pulse` = 0.
- `rst_n` asserted low while in OFF:
  - immediately `pwr_en` = 1, `iso_en` = 0, `domain_on` = 1, `pg_state` = 0.
- `sleep_req` and `wake_req` held high together from reset:
  - the sequencer cycles the full sleep/wake loop continuously;
  - the assertion "`pwr_en` = 0 implies `iso_en` = 1" never fires.
